// File: rtl/usb_defs.sv
`default_nettype none
// ============================================================================
// Module      : usb_defs (package)
// Description : State encodings and SETUP-packet match constants shared by
//               the enumeration sequencer and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_defs;

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue  = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_settle = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;
    localparam logic [2:0] c_st_fail   = 3'd5;

    localparam logic [7:0] c_set_addr_type = 8'h00;
    localparam logic [7:0] c_set_addr_req  = 8'h05;

    // byte0 = bmRequestType, byte1 = bRequest (little-endian packet)
    function automatic logic is_set_address(input logic [63:0] pkt);
        return (pkt[7:0] == c_set_addr_type) && (pkt[15:8] == c_set_addr_req);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gen_mux.sv
`default_nettype none
// ============================================================================
// Module      : gen_mux
// Description : Generic N-way word multiplexer over a flat packed bus.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_mux #(
    parameter int N     = 2,
    parameter int W     = 8,
    parameter int SEL_W = 1
) (
    input  logic [N*W-1:0]   i_data,
    input  logic [SEL_W-1:0] i_sel,
    output logic [W-1:0]     o_data
);

    logic [W-1:0] w_words [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word
            assign w_words[gi] = i_data[gi*W +: W];
        end
    endgenerate

    // Out-of-range selects yield zero
    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            if (i_sel == SEL_W'(i)) o_data = w_words[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_enum_timer.sv
`default_nettype none
// ============================================================================
// Module      : usb_enum_timer
// Description : Saturating frame counter (en rising edges) and transfer
//               timeout counter with a registered timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_enum_timer
    import usb_defs::*;
#(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_restart,
    input  logic       i_en,
    input  logic       i_frame_clr,
    input  logic       i_to_clr,
    input  logic       i_to_run,
    output logic [7:0] o_frame_cnt,
    output logic       o_timeout
);

    localparam logic [23:0] c_to_last = 24'(TIMEOUT_CYC - 1);

    logic        r_en_d;
    logic [7:0]  r_frame_cnt;
    logic [23:0] r_to_cnt;
    logic        r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d      <= 1'b0;
            r_frame_cnt <= 8'd0;
            r_to_cnt    <= 24'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_en_d <= i_en;
            if (i_restart || i_frame_clr) begin
                r_frame_cnt <= 8'd0;
            end else if (i_en && !r_en_d && (r_frame_cnt != 8'hFF)) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            // Counter parks at its last value; the flag lags it by one cycle
            if (i_restart || i_to_clr) begin
                r_to_cnt  <= 24'd0;
                r_timeout <= 1'b0;
            end else if (i_to_run) begin
                if (r_to_cnt != c_to_last) r_to_cnt <= r_to_cnt + 24'd1;
                r_timeout <= (r_to_cnt == c_to_last);
            end
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: rtl/usb_enum_seq.sv
`default_nettype none
// ============================================================================
// Module      : usb_enum_seq
// Description : Walks a table of SETUP requests through a control-transfer
//               engine with retries, timeouts and inter-request settling.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_enum_seq
    import usb_defs::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_FRAMES = 2,
    parameter int MAX_RETRY     = 3,
    parameter int TIMEOUT_CYC   = 1000000
) (
    input  logic                 c,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 en,
    input  logic [64*NUM_REQ-1:0] req_table,
    output logic                 ctrl_start,
    output logic [63:0]          ctrl_d,
    output logic [6:0]           ctrl_addr,
    input  logic                 ctrl_done,
    input  logic                 ctrl_err,
    output logic [2:0]           req_idx,
    output logic [3:0]           retry_cnt,
    output logic                 done,
    output logic                 fail
);

    localparam logic [2:0] c_last_idx  = 3'(NUM_REQ - 1);
    localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);
    localparam logic [7:0] c_settle    = 8'(SETTLE_FRAMES);

    logic [2:0] r_state,     w_state_nxt;
    logic [2:0] r_req_idx,   w_idx_nxt;
    logic [3:0] r_retry_cnt, w_retry_nxt;
    logic [6:0] r_cur_addr,  w_addr_nxt;
    logic       w_start, w_to_clr, w_to_run, w_frame_clr, w_timeout;
    logic [7:0] w_frame_cnt;

    gen_mux #(
        .N     (NUM_REQ),
        .W     (64),
        .SEL_W (3)
    ) u_req_mux (
        .i_data (req_table),
        .i_sel  (r_req_idx),
        .o_data (ctrl_d)
    );

    usb_enum_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk         (c),
        .rst_n       (rst_n),
        .i_restart   (restart),
        .i_en        (en),
        .i_frame_clr (w_frame_clr),
        .i_to_clr    (w_to_clr),
        .i_to_run    (w_to_run),
        .o_frame_cnt (w_frame_cnt),
        .o_timeout   (w_timeout)
    );

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_req_idx   <= 3'd0;
            r_retry_cnt <= 4'd0;
            r_cur_addr  <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_idx   <= w_idx_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_cur_addr  <= w_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_req_idx;
        w_retry_nxt = r_retry_cnt;
        w_addr_nxt  = r_cur_addr;
        w_start     = 1'b0;
        w_to_clr    = 1'b0;
        w_to_run    = 1'b0;
        w_frame_clr = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (en) w_state_nxt = c_st_issue;
            end
            c_st_issue: begin
                w_start     = 1'b1;
                w_to_clr    = 1'b1;
                w_state_nxt = c_st_wait;
            end
            c_st_wait: begin
                w_to_run = 1'b1;
                // Completion outranks a coincident error
                if (ctrl_done) begin
                    w_frame_clr = 1'b1;
                    w_state_nxt = c_st_settle;
                    if (is_set_address(ctrl_d)) w_addr_nxt = ctrl_d[22:16];
                end else if (ctrl_err || w_timeout) begin
                    if (r_retry_cnt < c_max_retry) begin
                        w_retry_nxt = r_retry_cnt + 4'd1;
                        w_state_nxt = c_st_issue;
                    end else begin
                        w_state_nxt = c_st_fail;
                    end
                end
            end
            c_st_settle: begin
                if (w_frame_cnt >= c_settle) begin
                    if (r_req_idx == c_last_idx) begin
                        w_state_nxt = c_st_done;
                    end else begin
                        w_idx_nxt   = r_req_idx + 3'd1;
                        w_retry_nxt = 4'd0;
                        w_state_nxt = c_st_issue;
                    end
                end
            end
            c_st_done, c_st_fail: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (restart) begin
            w_state_nxt = c_st_idle;
            w_idx_nxt   = 3'd0;
            w_retry_nxt = 4'd0;
            w_addr_nxt  = 7'd0;
            w_start     = 1'b0;
        end
    end

    assign ctrl_start = w_start;
    assign ctrl_addr  = r_cur_addr;
    assign req_idx    = r_req_idx;
    assign retry_cnt  = r_retry_cnt;
    assign done       = (r_state == c_st_done);
    assign fail       = (r_state == c_st_fail);

endmodule
`default_nettype wire

// File: tb/tb_usb_enum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_enum_seq
// Description : Directed self-checking bench for usb_enum_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_enum_seq;

    localparam logic [63:0] c_req0 = 64'h0000_0000_0001_0500; // SET_ADDRESS 1
    localparam logic [63:0] c_req1 = 64'h0000_0000_0001_0900; // SET_CONFIGURATION 1

    logic         c = 1'b0;
    logic         rst_n, restart, en, ctrl_done, ctrl_err;
    logic [127:0] req_table;
    logic         ctrl_start, done, fail;
    logic [63:0]  ctrl_d;
    logic [6:0]   ctrl_addr;
    logic [2:0]   req_idx;
    logic [3:0]   retry_cnt;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 c = ~c;

    usb_enum_seq #(
        .NUM_REQ       (2),
        .SETTLE_FRAMES (2),
        .MAX_RETRY     (3),
        .TIMEOUT_CYC   (100)
    ) dut (
        .c          (c),
        .rst_n      (rst_n),
        .restart    (restart),
        .en         (en),
        .req_table  (req_table),
        .ctrl_start (ctrl_start),
        .ctrl_d     (ctrl_d),
        .ctrl_addr  (ctrl_addr),
        .ctrl_done  (ctrl_done),
        .ctrl_err   (ctrl_err),
        .req_idx    (req_idx),
        .retry_cnt  (retry_cnt),
        .done       (done),
        .fail       (fail)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    // Two en rising edges; the SETTLE exit lands on the last tick
    task automatic settle2();
        en = 1'b1; tick();
        en = 1'b0; tick();
        en = 1'b1; tick();
        en = 1'b0; tick();
    endtask

    task automatic wait_start(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!ctrl_start && cnt < max);
    endtask

    task automatic wait_fail(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!fail && cnt < max);
    endtask

    initial begin
        rst_n = 1'b1; restart = 1'b0; en = 1'b0;
        ctrl_done = 1'b0; ctrl_err = 1'b0;
        req_table = {c_req1, c_req0};
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_start", 64'(ctrl_start), 64'd0);
        chk("rst_idx",   64'(req_idx),    64'd0);
        chk("rst_retry", 64'(retry_cnt),  64'd0);
        chk("rst_addr",  64'(ctrl_addr),  64'd0);
        chk("rst_done",  64'(done),       64'd0);
        chk("rst_fail",  64'(fail),       64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_nostart", 64'(ctrl_start), 64'd0);

        // Full two-request enumeration
        en = 1'b1; tick(); en = 1'b0;
        chk("r0_start", 64'(ctrl_start), 64'd1);
        chk("r0_d",     ctrl_d,          c_req0);
        chk("r0_addr",  64'(ctrl_addr),  64'd0);
        tick();
        chk("r0_wait_nostart", 64'(ctrl_start), 64'd0);
        ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
        chk("r0_addr_loaded", 64'(ctrl_addr), 64'd1);
        settle2();
        chk("r1_start", 64'(ctrl_start), 64'd1);
        chk("r1_idx",   64'(req_idx),    64'd1);
        chk("r1_d",     ctrl_d,          c_req1);
        chk("r1_addr",  64'(ctrl_addr),  64'd1);
        tick();
        ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
        settle2();
        chk("done_rise", 64'(done), 64'd1);
        tick(); tick();
        chk("done_hold",    64'(done),       64'd1);
        chk("done_nostart", 64'(ctrl_start), 64'd0);
        restart = 1'b1; tick(); restart = 1'b0;
        chk("rs_done", 64'(done),      64'd0);
        chk("rs_addr", 64'(ctrl_addr), 64'd0);
        chk("rs_idx",  64'(req_idx),   64'd0);

        // Two errors, then coincident done+err on the third attempt
        en = 1'b1; tick(); en = 1'b0;
        chk("e_start0", 64'(ctrl_start), 64'd1);
        tick();
        ctrl_err = 1'b1; tick(); ctrl_err = 1'b0;
        chk("e_start1", 64'(ctrl_start), 64'd1);
        chk("e_retry1", 64'(retry_cnt),  64'd1);
        tick();
        ctrl_err = 1'b1; tick(); ctrl_err = 1'b0;
        chk("e_start2", 64'(ctrl_start), 64'd1);
        chk("e_retry2", 64'(retry_cnt),  64'd2);
        tick();
        ctrl_done = 1'b1; ctrl_err = 1'b1; tick();
        ctrl_done = 1'b0; ctrl_err = 1'b0;
        chk("both_retry", 64'(retry_cnt),  64'd2);
        chk("both_addr",  64'(ctrl_addr), 64'd1);
        chk("both_start", 64'(ctrl_start), 64'd0);
        ctrl_err = 1'b1; tick(); ctrl_err = 1'b0;
        chk("ign_err_retry", 64'(retry_cnt),  64'd2);
        chk("ign_err_start", 64'(ctrl_start), 64'd0);
        settle2();
        chk("e_r1_start", 64'(ctrl_start), 64'd1);
        chk("e_r1_retry", 64'(retry_cnt),  64'd0);

        // Restart while waiting on request 1
        tick();
        restart = 1'b1; tick(); restart = 1'b0;
        chk("rw_addr",  64'(ctrl_addr),  64'd0);
        chk("rw_idx",   64'(req_idx),    64'd0);
        chk("rw_start", 64'(ctrl_start), 64'd0);
        en = 1'b1; tick(); en = 1'b0;
        chk("rw_reissue", 64'(ctrl_start), 64'd1);
        chk("rw_d",       ctrl_d,          c_req0);
        restart = 1'b1; #1;
        chk("rs_suppress", 64'(ctrl_start), 64'd0);
        tick(); restart = 1'b0;

        // Timeouts: ctrl_start every 102 cycles, FAIL after 4 attempts
        en = 1'b1; tick(); en = 1'b0;
        chk("to_start0", 64'(ctrl_start), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            wait_start(300, n);
            chk("to_period", 64'(n),         64'd102);
            chk("to_retry",  64'(retry_cnt), 64'(k));
        end
        wait_fail(300, n);
        chk("to_fail_lat", 64'(n),    64'd102);
        tick(); tick();
        chk("fail_hold",    64'(fail),       64'd1);
        chk("fail_nostart", 64'(ctrl_start), 64'd0);
        restart = 1'b1; tick(); restart = 1'b0;
        chk("rs_fail", 64'(fail), 64'd0);

        // Asynchronous reset in the middle of SETTLE for request 1
        en = 1'b1; tick(); en = 1'b0;
        tick();
        ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
        settle2();
        tick();
        ctrl_done = 1'b1; tick(); ctrl_done = 1'b0;
        chk("pre_rst_idx", 64'(req_idx), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_idx",   64'(req_idx),    64'd0);
        chk("ar_addr",  64'(ctrl_addr),  64'd0);
        chk("ar_retry", 64'(retry_cnt),  64'd0);
        chk("ar_start", 64'(ctrl_start), 64'd0);
        chk("ar_done",  64'(done),       64'd0);
        tick(); tick();
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ctrl_start) n++;
        end
        chk("ar_quiet", 64'(n), 64'd0);
        en = 1'b1; tick(); en = 1'b0;
        chk("ar_en_start", 64'(ctrl_start), 64'd1);
        chk("ar_en_idx",   64'(req_idx),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
